// File: rtl/frame_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_ctrl_pkg : state type, status codes and default command byte
// Revision: 1.0
// ---------------------------------------------------------------------------
package frame_ctrl_pkg;

    typedef enum logic [1:0] {
        S_WAIT      = 2'd0,
        S_TRANSPORT = 2'd1,
        S_DISPLAY   = 2'd2,
        S_ERROR     = 2'd3
    } state_e;

    localparam logic [7:0] ST_WAIT          = 8'h01;
    localparam logic [7:0] ST_TRANSPORT     = 8'h02;
    localparam logic [7:0] ST_DISPLAY       = 8'h03;
    localparam logic [7:0] ST_ERROR         = 8'h04;
    localparam logic [7:0] DEFAULT_CMD_BYTE = 8'h5A;

    function automatic logic [7:0] status_code(input state_e s);
        case (s)
            S_TRANSPORT: status_code = ST_TRANSPORT;
            S_DISPLAY:   status_code = ST_DISPLAY;
            S_ERROR:     status_code = ST_ERROR;
            default:     status_code = ST_WAIT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_ctrl_wdt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_ctrl_wdt : idle-cycle watchdog, terminal at TIMEOUT_CYC-1
// Revision: 1.0
// ---------------------------------------------------------------------------
module frame_ctrl_wdt #(
    parameter int unsigned TIMEOUT_CYC = 32'd5_000_000
) (
    input  logic i_clk_sys,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != TERM)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_term = (cnt_q == TERM);

endmodule
`default_nettype wire

// File: rtl/frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_ctrl : start-command decode, image byte counting, display/error modes
// Optional watchdog/ERROR state: define FRAME_CTRL_TIMEOUT_EN.  Revision: 1.0
// ---------------------------------------------------------------------------
module frame_ctrl
    import frame_ctrl_pkg::*;
#(
    parameter logic [7:0]  CMD_BYTE    = DEFAULT_CMD_BYTE,
    parameter int unsigned IMG_BYTES   = 32'd153600,
    parameter int unsigned TIMEOUT_CYC = 32'd5_000_000,
    parameter int unsigned ADDR_W      = $clog2(IMG_BYTES)
) (
    input  logic              i_clk_sys,
    input  logic              i_rst,
    input  logic [7:0]        i_data,
    input  logic              i_rx_done,
    output logic [7:0]        o_state,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_frame_done,
    output logic              o_err
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_BYTES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        status_q, status_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;

    wire w_cmd = i_rx_done && (i_data == CMD_BYTE);

`ifdef FRAME_CTRL_TIMEOUT_EN
    logic w_wdt_term;
    logic err_q, err_d;

    // Any received byte in TRANSPORT is payload, so it always resets the watchdog.
    frame_ctrl_wdt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdt (
        .i_clk_sys (i_clk_sys),
        .i_rst     (i_rst),
        .i_clr     ((state_q != S_TRANSPORT) || i_rx_done),
        .i_en      ((state_q == S_TRANSPORT) && !i_rx_done),
        .o_term    (w_wdt_term)
    );
`endif

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_WAIT;
            cnt_q    <= '0;
            status_q <= ST_WAIT;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
`ifdef FRAME_CTRL_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
`ifdef FRAME_CTRL_TIMEOUT_EN
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (w_cmd) state_d = S_TRANSPORT;
            end
            S_TRANSPORT: begin
                if (i_rx_done && (cnt_q == LAST)) state_d = S_DISPLAY;
`ifdef FRAME_CTRL_TIMEOUT_EN
                else if (!i_rx_done && w_wdt_term) state_d = S_ERROR;
`endif
            end
            S_DISPLAY: begin
                if (w_cmd) state_d = S_WAIT;
            end
`ifdef FRAME_CTRL_TIMEOUT_EN
            S_ERROR: begin
                if (w_cmd) state_d = S_WAIT;
            end
`endif
            default: state_d = S_WAIT;
        endcase
    end

    // Output registers are loaded from the next state so they share its latency.
    always_comb begin
        cnt_d    = cnt_q;
        wr_en_d  = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        status_d = status_code(state_d);
        if ((state_q == S_WAIT) && w_cmd) begin
            cnt_d = '0;
        end
        if ((state_q == S_TRANSPORT) && i_rx_done) begin
            wr_en_d = 1'b1;
            addr_d  = cnt_q;
            data_d  = i_data;
            if (cnt_q == LAST) begin
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
    end

`ifdef FRAME_CTRL_TIMEOUT_EN
    assign err_d = (state_d == S_ERROR);
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_state      = status_q;
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = addr_q;
    assign o_wr_data    = data_q;
    assign o_frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_frame_ctrl : directed stimulus, mode-level reference model, per-cycle compare
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_frame_ctrl;
    localparam int IMG = 4;
    localparam int TO  = 8;
    localparam int AW  = $clog2(IMG);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    data = 8'h00;
    logic          rx = 1'b0;
    wire  [7:0]    o_state;
    wire           o_wr_en;
    wire  [AW-1:0] o_wr_addr;
    wire  [7:0]    o_wr_data;
    wire           o_frame_done;
    wire           o_err;

    always #5 clk = ~clk;

    frame_ctrl #(
        .CMD_BYTE    (8'h5A),
        .IMG_BYTES   (IMG),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk_sys    (clk),
        .i_rst        (rst),
        .i_data       (data),
        .i_rx_done    (rx),
        .o_state      (o_state),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_frame_done (o_frame_done),
        .o_err        (o_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 1..4 equals the status code directly.
    int            m_mode = 1;
    int            m_cnt  = 0;
    int            m_idle = 0;
    logic          e_we   = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [7:0]    e_data = 8'h00;
    logic          e_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 1; m_cnt = 0; m_idle = 0;
        e_we = 1'b0; e_addr = '0; e_data = 8'h00; e_done = 1'b0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            e_we = 1'b0;
            e_done = 1'b0;
            case (m_mode)
                1: if (rx && data == 8'h5A) begin m_mode = 2; m_cnt = 0; m_idle = 0; end
                2: begin
                    if (rx) begin
                        e_we = 1'b1;
                        e_addr = m_cnt[AW-1:0];
                        e_data = data;
                        m_idle = 0;
                        if (m_cnt == IMG - 1) begin
                            m_mode = 3;
                            e_done = 1'b1;
                        end else begin
                            m_cnt = m_cnt + 1;
                        end
                    end else begin
`ifdef FRAME_CTRL_TIMEOUT_EN
                        m_idle = m_idle + 1;
                        if (m_idle >= TO) m_mode = 4;
`endif
                    end
                end
                default: if (rx && data == 8'h5A) m_mode = 1;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        data = b;
        rx = 1'b1;
        tick();
        rx = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, {24'h0, o_state}, 32'h01);
        chk({tag, "_wr_en"}, {31'h0, o_wr_en}, 32'h0);
        chk({tag, "_addr"}, {{(32-AW){1'b0}}, o_wr_addr}, 32'h0);
        chk({tag, "_data"}, {24'h0, o_wr_data}, 32'h0);
        chk({tag, "_done"}, {31'h0, o_frame_done}, 32'h0);
        chk({tag, "_err"}, {31'h0, o_err}, 32'h0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("cmp_state", {24'h0, o_state}, m_mode);
            chk("cmp_wr_en", {31'h0, o_wr_en}, {31'h0, e_we});
            chk("cmp_addr", {{(32-AW){1'b0}}, o_wr_addr}, {{(32-AW){1'b0}}, e_addr});
            chk("cmp_data", {24'h0, o_wr_data}, {24'h0, e_data});
            chk("cmp_done", {31'h0, o_frame_done}, {31'h0, e_done});
            chk("cmp_err", {31'h0, o_err}, (m_mode == 4) ? 32'h1 : 32'h0);
        end
    end

    initial begin
        model_reset();
        idle(3);
        chk_reset_values("rst");
        rst = 1'b0;

        send(8'h11);
        chk("ignore_state", {24'h0, o_state}, 32'h01);
        send(8'h5A);
        chk("start_state", {24'h0, o_state}, 32'h02);
        chk("start_no_wr", {31'h0, o_wr_en}, 32'h0);

        // Payload back-to-back, first byte equals the command value.
        send(8'h5A);
        chk("p0_wr", {31'h0, o_wr_en}, 32'h1);
        chk("p0_addr", {30'h0, o_wr_addr}, 32'h0);
        chk("p0_data", {24'h0, o_wr_data}, 32'h5A);
        chk("p0_state", {24'h0, o_state}, 32'h02);
        send(8'h01);
        chk("p1_addr", {30'h0, o_wr_addr}, 32'h1);
        send(8'h02);
        chk("p2_data", {24'h0, o_wr_data}, 32'h02);
        send(8'h03);
        chk("p3_addr", {30'h0, o_wr_addr}, 32'h3);
        chk("p3_done", {31'h0, o_frame_done}, 32'h1);
        chk("p3_state", {24'h0, o_state}, 32'h03);
        idle(1);
        chk("hold_wr", {31'h0, o_wr_en}, 32'h0);
        chk("hold_data", {24'h0, o_wr_data}, 32'h03);
        chk("done_pulse", {31'h0, o_frame_done}, 32'h0);

        send(8'h00);
        chk("disp_ignore", {24'h0, o_state}, 32'h03);
        send(8'h5A);
        chk("disp_exit", {24'h0, o_state}, 32'h01);

`ifdef FRAME_CTRL_TIMEOUT_EN
        send(8'h5A);
        send(8'h77);
        idle(TO - 1);
        chk("wdt_pre_state", {24'h0, o_state}, 32'h02);
        idle(1);
        chk("wdt_err_state", {24'h0, o_state}, 32'h04);
        chk("wdt_err_flag", {31'h0, o_err}, 32'h1);
        send(8'h33);
        chk("err_ignore", {24'h0, o_state}, 32'h04);
        send(8'h5A);
        chk("err_exit", {24'h0, o_state}, 32'h01);
        chk("err_clear", {31'h0, o_err}, 32'h0);

        // Byte on the terminal cycle wins over the timeout.
        send(8'h5A);
        send(8'h10);
        idle(TO - 1);
        send(8'h20);
        chk("term_state", {24'h0, o_state}, 32'h02);
        chk("term_addr", {30'h0, o_wr_addr}, 32'h1);
        chk("term_err", {31'h0, o_err}, 32'h0);
        send(8'h30);
        send(8'h40);
        chk("term_done", {24'h0, o_state}, 32'h03);
        send(8'h5A);
`else
        send(8'h5A);
        send(8'h77);
        idle(50000);
        chk("nowdt_state", {24'h0, o_state}, 32'h02);
        chk("nowdt_err", {31'h0, o_err}, 32'h0);
        send(8'h78);
        send(8'h79);
        send(8'h7A);
        chk("nowdt_done", {24'h0, o_state}, 32'h03);
        send(8'h5A);
`endif

        // Asynchronous reset in the middle of a transfer.
        send(8'h5A);
        send(8'hA1);
        send(8'hA2);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_reset_values("arst");
        tick();
        rst = 1'b0;
        send(8'h5A);
        send(8'hB0);
        chk("rest_addr", {30'h0, o_wr_addr}, 32'h0);
        chk("rest_data", {24'h0, o_wr_data}, 32'hB0);
        send(8'hB1);
        send(8'hB2);
        send(8'hB3);
        chk("rest_done", {31'h0, o_frame_done}, 32'h1);
        chk("rest_state", {24'h0, o_state}, 32'h03);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
